alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Shares one combinational ALU among NUM_REQ requesters, using round-robin arbitration.
- Every accepted operation runs on the ALU twice: once in EXEC1 and, when CHECK_EN=1, again in EXEC2. The two results are compared to detect transient faults.
- Returns the result with the requester ID and a status code. Status encoding matches the fault dataset labels: 0 ok, 1 result corruption, 2 opcode fault.
- Sits between the requester ports and the external alu instance; drives its a/b/opcode and samples its result.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width.
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.
- CHECK_EN, 1, 1 = dual execution and compare; 0 = single execution, no compare.
- CNT_W, 16, width of the fault counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  operand a, requester i in slice [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  operand b, same packing as req_a.
- req_opcode  in  NUM_REQ*3  opcode, requester i in slice [i*3 +: 3].
- alu_a  out  DATA_W  to ALU a.
- alu_b  out  DATA_W  to ALU b.
- alu_opcode  out  3  to ALU opcode.
- alu_result  in  DATA_W  from ALU result, combinational.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  requester index of the response.
- rsp_result  out  DATA_W  result.
- rsp_status  out  2  0 ok, 1 mismatch, 2 illegal opcode.
- fault_count  out  CNT_W  saturating count of status 1 and status 2 responses.

Behaviour:
- Reset (async assert, sync deassert):
  - State IDLE; all outputs 0.
  - Round-robin pointer set so requester 0 has highest priority.
  - Any in-flight operation is discarded; no response is produced for it.
- States: IDLE, EXEC1, EXEC2, RESP.
- IDLE:
  - The grant g is the first asserted req_valid searching from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[g] is asserted combinationally in the same cycle; all other ready bits stay 0.
  - On grant: capture a, b, opcode and g into internal registers, then go to EXEC1.
  - If no request is valid, stay in IDLE.
- Operand handling: requesters hold a, b and opcode stable while valid and not ready. Operands are sampled only at the accepting edge.
- EXEC1:
  - alu_a, alu_b and alu_opcode are driven from the registers. alu_opcode is registered, not combinational from req_*.
  - On the clock edge, alu_result is captured into res1.
  - Go to EXEC2 if CHECK_EN=1, else go to RESP.
- EXEC2:
  - The ALU is driven with the same operands again.
  - On the clock edge, res2 is captured and mismatch = (res1 != res2) is recorded.
  - Go to RESP.
- Illegal opcode (>4):
  - EXEC states are still traversed, so latency is uniform.
  - rsp_result = 32'hDEAD_BEEF (zero-extended or truncated to DATA_W); rsp_status = 2; mismatch is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result (=res1) and rsp_status are held stable until rsp_ready.
  - On the valid&ready handshake: last_grant updates to the served ID, state returns to IDLE, and fault_count increments if status != 0, saturating at all-ones.
- ALU outputs in IDLE and RESP: alu_a, alu_b and alu_opcode are held at 0.
- Latency, request accept edge T to rsp_valid: 3 cycles with CHECK_EN=1; 2 cycles with CHECK_EN=0. Throughput is one operation per 4 (or 3) cycles when rsp_ready=1.
- No new grant is made while busy. req_ready is 0 in EXEC1, EXEC2 and RESP.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4;
  - ALU_ILLEGAL_RESULT=32'hDEAD_BEEF;
  - status codes ST_OK=0, ST_MISMATCH=1, ST_ILLEGAL=2;
  - the state encoding.
- Sub-module rr_arbiter(NUM_REQ): inputs req, last_grant and enable; outputs one-hot grant and a valid flag. It is purely combinational; the pointer lives in alu_sched.

Test Plan:
- Single request: req0 with a=5, b=3, op=ADD; rsp_ready=1 → req_ready[0] is 1 for one cycle; rsp_valid 3 cycles later with rsp_result=8, rsp_id=0, rsp_status=0.
- Round-robin: all 4 requesters valid continuously, with op=SUB, a=10, b=i → response order 0,1,2,3,0, results 10,9,8,7,10.
- Fault detection: bench forces alu_result ^= 32'h0000_0004 during EXEC2 only, for a=1, b=2, op=OR → rsp_result=3, rsp_status=1, fault_count increments to 1.
- Illegal opcode: op=7, a=b=0 → rsp_result=32'hDEAD_BEEF, rsp_status=2, latency still 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_* held stable, req_ready stays 0; the next grant occurs only after the handshake.
- Mid-operation reset: assert rst in EXEC2 → rsp_valid=0 and fault_count=0 immediately; after release, requester 0 wins the first grant.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcodes, status codes and scheduler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  localparam logic [31:0] ALU_ILLEGAL_RESULT = 32'hDEAD_BEEF;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_MISMATCH = 2'd1;
  localparam logic [1:0] ST_ILLEGAL  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC1 = 2'd1,
    S_EXEC2 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op > OP_XOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sched_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant; searches from last_grant+1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  // Each requester's distance from the priority pointer; smallest requesting one wins.
  always_comb begin : p_arb
    int w_dist;
    int w_best_dist;
    int w_best_idx;
    w_dist      = 0;
    w_best_dist = NUM_REQ;
    w_best_idx  = 0;
    valid       = 1'b0;
    grant       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(last_grant) - 1;
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if (req[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best_idx  = i;
      end
    end
    valid = enable && (w_best_dist < NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = valid && (i == w_best_idx);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_sched.sv
// ============================================================================
//  Module      : alu_sched
//  Description : Round-robin scheduler sharing one external ALU, with optional
//                dual execution and compare for transient-fault detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sched #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 2,
  parameter bit CHECK_EN = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]      req_opcode,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [2:0]                alu_opcode,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [1:0]                rsp_status,
  output logic [CNT_W-1:0]          fault_count
);

  import alu_pkg::*;

  localparam logic [DATA_W-1:0] c_ILLEGAL_RES = DATA_W'(ALU_ILLEGAL_RESULT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [2:0]          r_op;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_last;
  logic [DATA_W-1:0]   r_res1;
  logic                r_mismatch;
  logic [CNT_W-1:0]    r_fault_cnt;

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_gnt_valid;
  logic [ID_W-1:0]     w_gnt_id;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [2:0]          w_sel_op;
  logic                w_illegal;
  logic [1:0]          w_status;
  logic                w_exec;
  logic                w_resp;
  logic                w_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (r_last),
    .enable     (r_state == S_IDLE),
    .grant      (w_grant),
    .valid      (w_gnt_valid)
  );

  always_comb begin
    w_gnt_id = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_id = ID_W'(i);
        w_sel_a  = req_a[i*DATA_W +: DATA_W];
        w_sel_b  = req_b[i*DATA_W +: DATA_W];
        w_sel_op = req_opcode[i*3 +: 3];
      end
    end
  end

  // An illegal opcode overrides any compare result.
  assign w_illegal = op_is_illegal(r_op);
  assign w_status  = w_illegal  ? ST_ILLEGAL  :
                     r_mismatch ? ST_MISMATCH : ST_OK;
  assign w_exec    = (r_state == S_EXEC1) || (r_state == S_EXEC2);
  assign w_resp    = (r_state == S_RESP);
  assign w_hs      = w_resp && rsp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_valid) w_state_nxt = S_EXEC1;
      S_EXEC1: w_state_nxt = CHECK_EN ? S_EXEC2 : S_RESP;
      S_EXEC2: w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_id        <= '0;
      r_last      <= ID_W'(NUM_REQ - 1);
      r_res1      <= '0;
      r_mismatch  <= 1'b0;
      r_fault_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && w_gnt_valid) begin
        r_a        <= w_sel_a;
        r_b        <= w_sel_b;
        r_op       <= w_sel_op;
        r_id       <= w_gnt_id;
        r_mismatch <= 1'b0;
      end
      if (r_state == S_EXEC1) r_res1 <= alu_result;
      if (r_state == S_EXEC2) r_mismatch <= (r_res1 != alu_result);
      if (w_hs) begin
        r_last <= r_id;
        if ((w_status != ST_OK) && (r_fault_cnt != {CNT_W{1'b1}})) begin
          r_fault_cnt <= r_fault_cnt + 1'b1;
        end
      end
    end
  end

  assign req_ready   = w_grant;
  assign alu_a       = w_exec ? r_a  : '0;
  assign alu_b       = w_exec ? r_b  : '0;
  assign alu_opcode  = w_exec ? r_op : 3'd0;
  assign rsp_valid   = w_resp;
  assign rsp_id      = w_resp ? r_id : '0;
  assign rsp_result  = !w_resp  ? '0            :
                       w_illegal ? c_ILLEGAL_RES : r_res1;
  assign rsp_status  = w_resp ? w_status : ST_OK;
  assign fault_count = r_fault_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_sched.sv
// ============================================================================
//  Module      : tb_alu_sched
//  Description : Scoreboard bench for alu_sched with an external ALU model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sched;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a = '0;
  logic [NUM_REQ*DATA_W-1:0] req_b = '0;
  logic [NUM_REQ*3-1:0]      req_opcode = '0;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [2:0]                alu_opcode;
  logic [DATA_W-1:0]         alu_result;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic [1:0]                rsp_status;
  logic [CNT_W-1:0]          fault_count;

  always #5 clk = ~clk;

  alu_sched #(
    .NUM_REQ (NUM_REQ), .DATA_W (DATA_W), .ID_W (ID_W), .CHECK_EN (1'b1), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_a (req_a), .req_b (req_b), .req_opcode (req_opcode),
    .alu_a (alu_a), .alu_b (alu_b), .alu_opcode (alu_opcode), .alu_result (alu_result),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_id (rsp_id),
    .rsp_result (rsp_result), .rsp_status (rsp_status), .fault_count (fault_count)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int off = 1; off <= NUM_REQ; off++) begin
      int idx;
      idx = (last + off) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // External ALU; optionally flips bit 2 in the cycle two after acceptance.
  logic inject = 1'b0;
  int   since_acc = 99;
  assign alu_result = alu_f(alu_a, alu_b, alu_opcode) ^
                      ((inject && since_acc == 2) ? 32'h4 : 32'h0);

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic [1:0]  st;
  } exp_t;

  exp_t             q[$];
  int               served[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               m_last  = NUM_REQ - 1;
  bit               m_busy  = 1'b0;
  int               m_fault = 0;
  int               hs_count = 0;
  int               cyc = 0;
  int               acc_cyc = 0;
  bit               wait_first = 1'b0;
  logic [NUM_REQ-1:0] acc_mask = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
  endtask

  // Monitor / scoreboard
  initial begin : mon
    int   g;
    exp_t e;
    logic [NUM_REQ-1:0] er;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        m_busy     = 1'b0;
        m_last     = NUM_REQ - 1;
        m_fault    = 0;
        wait_first = 1'b0;
        since_acc  = 99;
        acc_mask   = '0;
      end else begin
        chk("fault_count", 32'(fault_count), 32'(m_fault));
        since_acc = (req_ready != '0) ? 0 : ((since_acc < 99) ? since_acc + 1 : 99);
        acc_mask  = req_ready;
        if (!m_busy) begin
          chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
          g  = rr_pick(req_valid, m_last);
          er = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
          chk("req_ready_grant", 32'(req_ready), 32'(er));
          if (g >= 0) begin
            ra   = req_a[g*DATA_W +: DATA_W];
            rb   = req_b[g*DATA_W +: DATA_W];
            rop  = req_opcode[g*3 +: 3];
            e.id = 2'(g);
            if (rop > 3'd4) begin
              e.res = 32'hDEAD_BEEF;
              e.st  = 2'd2;
            end else begin
              e.res = alu_f(ra, rb, rop);
              e.st  = inject ? 2'd1 : 2'd0;
            end
            q.push_back(e);
            m_busy     = 1'b1;
            acc_cyc    = cyc;
            wait_first = 1'b1;
          end
        end else begin
          chk("req_ready_busy", 32'(req_ready), 32'd0);
          if (rsp_valid && wait_first) begin
            chk("latency", 32'(cyc - acc_cyc), 32'd3);
            wait_first = 1'b0;
          end
          if (rsp_valid) begin
            if (q.size() == 0) begin
              timeout("unexpected_rsp");
            end else begin
              chk("rsp_id",     32'(rsp_id),     32'(q[0].id));
              chk("rsp_result", rsp_result,      q[0].res);
              chk("rsp_status", 32'(rsp_status), 32'(q[0].st));
              if (rsp_ready) begin
                e      = q.pop_front();
                m_last = int'(e.id);
                m_busy = 1'b0;
                if (e.st != 2'd0 && m_fault < 65535) m_fault++;
                hs_count++;
                served.push_back(int'(e.id));
              end
            end
          end
        end
      end
    end
  end

  task automatic drive_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
    req_a[i*DATA_W +: DATA_W] = a;
    req_b[i*DATA_W +: DATA_W] = b;
    req_opcode[i*3 +: 3]      = op;
    req_valid[i]              = 1'b1;
  endtask

  task automatic wait_accept(input int i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    if (!ok) timeout("accept");
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(posedge clk); #1;
      if (!m_busy && q.size() == 0) ok = 1'b1;
    end
    if (!ok) timeout("idle");
  endtask

  initial begin : stim
    int base;
    bit ok;
    @(posedge clk); #1;
    chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    chk("rst_rsp_result",  rsp_result,       32'd0);
    chk("rst_rsp_id",      32'(rsp_id),      32'd0);
    chk("rst_rsp_status",  32'(rsp_status),  32'd0);
    chk("rst_fault_count", 32'(fault_count), 32'd0);
    chk("rst_req_ready",   32'(req_ready),   32'd0);
    chk("rst_alu_opcode",  32'(alu_opcode),  32'd0);
    chk("rst_alu_a",       alu_a,            32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single request
    drive_req(0, 32'd5, 32'd3, 3'd0);
    wait_accept(0);
    wait_idle(20);

    // fault detected on the second execution
    inject = 1'b1;
    drive_req(2, 32'd1, 32'd2, 3'd3);
    wait_accept(2);
    wait_idle(20);
    inject = 1'b0;
    chk("fault_count_after_fault", 32'(fault_count), 32'd1);

    // illegal opcode
    drive_req(1, 32'd0, 32'd0, 3'd7);
    wait_accept(1);
    wait_idle(20);

    // backpressure: hold response, competing request must wait
    rsp_ready = 1'b0;
    drive_req(3, 32'h1234_5678, 32'h0F0F_0F0F, 3'd2);
    wait_accept(3);
    drive_req(0, 32'd100, 32'd1, 3'd1);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) timeout("bp_rsp_valid");
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_accept(0);
    wait_idle(20);

    // reset in the middle of an operation
    drive_req(1, 32'd7, 32'd8, 3'd4);
    wait_accept(1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid",   32'(rsp_valid),   32'd0);
    chk("midrst_fault_count", 32'(fault_count), 32'd0);
    chk("midrst_alu_opcode",  32'(alu_opcode),  32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // round-robin with all requesters continuously valid
    served.delete();
    base = hs_count;
    for (int i = 0; i < NUM_REQ; i++) drive_req(i, 32'd10, 32'(i), 3'd1);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk); #1;
      if (hs_count >= base + 5) ok = 1'b1;
    end
    req_valid = '0;
    if (!ok) timeout("rr_handshakes");
    else begin
      chk("rr_order0", 32'(served[0]), 32'd0);
      chk("rr_order1", 32'(served[1]), 32'd1);
      chk("rr_order2", 32'(served[2]), 32'd2);
      chk("rr_order3", 32'(served[3]), 32'd3);
      chk("rr_order4", 32'(served[4]), 32'd0);
    end
    wait_idle(20);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask[i] || !req_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            drive_req(i, $urandom, $urandom, 3'($urandom_range(0, 7)));
          else
            req_valid[i] = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(40);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
